// File: rtl/io_access_ctrl.sv
// io_access_ctrl: sequences one CPU memory-mapped IO access at a time.
// It decodes the address, issues a single-cycle request to the selected
// peripheral and waits for its acknowledge or a timeout. The CPU is stalled
// while the access is in flight, and read data is latched for write-back.
module io_access_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  output logic        dev_req,
  output logic        dev_we,
  output logic [1:0]  dev_id,
  output logic [3:0]  dev_off,
  output logic [15:0] dev_wdata,
  input  logic [15:0] dev_rdata,
  input  logic        dev_ack
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  // Last WAIT cycle before the access is abandoned; the counter never wraps.
  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       err_pending;

  logic       access;
  logic       page_hit;
  logic       grp_hit;
  logic [1:0] grp_id;
  logic       dec_ok;
  logic       unused_wdata_hi;

  assign access          = io_read | io_write;
  assign page_hit        = (addr[31:8] == 24'hFFFFFC);
  assign dec_ok          = page_hit & grp_hit & (io_read ^ io_write);
  assign unused_wdata_hi = ^wdata[31:16];

  // Map the 16-byte address group onto a peripheral select.
  always_comb begin
    grp_hit = 1'b1;
    grp_id  = 2'd0;
    case (addr[7:4])
      4'h6:    grp_id = 2'd0;
      4'h7:    grp_id = 2'd1;
      4'h8:    grp_id = 2'd2;
      default: grp_hit = 1'b0;
    endcase
  end

  // The IDLE term is combinational so the CPU freezes in the issue cycle.
  assign stall = ((state == S_IDLE) & access) | (state == S_REQ) | (state == S_WAIT);
  assign err   = (state == S_DONE) & err_pending;

  // Access sequencer: IDLE -> REQ -> (WAIT) -> DONE -> IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      err_pending <= 1'b0;
      rdata       <= 32'd0;
      dev_req     <= 1'b0;
      dev_we      <= 1'b0;
      dev_id      <= 2'd0;
      dev_off     <= 4'd0;
      dev_wdata   <= 16'd0;
    end else begin
      dev_req <= 1'b0;
      case (state)
        S_IDLE: begin
          if (access) begin
            if (dec_ok) begin
              dev_id      <= grp_id;
              dev_off     <= addr[3:0];
              dev_wdata   <= wdata[15:0];
              dev_we      <= io_write;
              dev_req     <= 1'b1;
              err_pending <= 1'b0;
              state       <= S_REQ;
            end else begin
              // A failed read returns zero so write-back gets a defined value.
              if (io_read) begin
                rdata <= 32'd0;
              end
              err_pending <= 1'b1;
              state       <= S_DONE;
            end
          end
        end
        S_REQ: begin
          if (dev_ack) begin
            if (!dev_we) begin
              rdata <= {16'h0000, dev_rdata};
            end
            state <= S_DONE;
          end else begin
            cnt   <= 4'd0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dev_ack) begin
            if (!dev_we) begin
              rdata <= {16'h0000, dev_rdata};
            end
            state <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            if (!dev_we) begin
              rdata <= 32'd0;
            end
            err_pending <= 1'b1;
            state       <= S_DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_DONE: begin
          err_pending <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/io_access_ctrl.md
# io_access_ctrl

Multi-cycle sequencer for CPU memory-mapped IO accesses. Sits between the CPU's memory/IO steering logic and the peripherals (LED, switch, seven-segment). It decodes the IO address, issues a one-cycle request to the selected peripheral, and waits for its acknowledge or a timeout. While the access is in flight it stalls the single-cycle CPU, then returns latched read data for register write-back.

## Interface
- TIMEOUT, 15: cycles spent in WAIT without `dev_ack` before the access is aborted (1..15).
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_read  in  1  CPU IO read request; held stable while `stall`=1.
- io_write  in  1  CPU IO write request; held stable while `stall`=1.
- addr  in  32  IO byte address from the CPU.
- wdata  in  32  write data from the CPU; only bits [15:0] are forwarded.
- rdata  out  32  read data to write-back, zero-extended from 16 bits.
- stall  out  1  freezes PC and register-file writes while high.
- err  out  1  one-cycle pulse on decode error or timeout.
- dev_req  out  1  one-cycle request strobe to a peripheral.
- dev_we  out  1  1 = write, 0 = read; valid while `dev_req`=1.
- dev_id  out  2  peripheral select: 0 = LED (0xFFFF_FC6x), 1 = switch (0xFFFF_FC7x), 2 = seg (0xFFFF_FC8x).
- dev_off  out  4  `addr[3:0]`, registered.
- dev_wdata  out  16  `wdata[15:0]`, registered.
- dev_rdata  in  16  peripheral read data; valid when `dev_ack`=1.
- dev_ack  in  1  peripheral completion; one cycle or longer.

## Operation
- `access` = `io_read` | `io_write`.
- Decode is valid when `addr[31:8]`=24'hFFFFFC, `addr[7:4]` is in {6,7,8}, and exactly one of `io_read`/`io_write` is high.
  - `dev_id` = `addr[7:4]` − 6.
  - An invalid access is a decode error.
- FSM states:
  - IDLE
    - valid access: latch `dev_id`/`dev_off`/`dev_wdata`/`dev_we`, go to REQ.
    - decode error: go to DONE with `err_pending`.
    - no access: stay.
  - REQ
    - `dev_req`=1 for exactly this cycle.
    - `dev_ack` sampled: if high, complete, go to DONE; else go to WAIT and clear the timeout counter.
  - WAIT
    - `dev_ack`: complete, go to DONE.
    - counter reaches TIMEOUT: abort, go to DONE with `err_pending`.
    - otherwise increment the counter.
  - DONE
    - `stall`=0 and `err`=`err_pending`; the CPU commits at the end of this cycle.
    - always go to IDLE.
- Completion with `dev_we`=0: `rdata` ← {16'h0, `dev_rdata`}.
- Read decode error or read timeout: `rdata` ← 0.
- Write completion: `rdata` unchanged.
- `rdata` holds its value until the next read completion.
- `stall` = (state==IDLE & `access`) | state==REQ | state==WAIT. The IDLE term is combinational, so the CPU freezes in the issue cycle.
- If `access` drops mid-flight, the FSM still runs to DONE. No new `dev_req` is issued, and `stall` follows the state terms.
- A `dev_ack` arriving in IDLE or DONE is ignored.
- Counter width is 4 bits and must not wrap: TIMEOUT ≤ 15.

## Timing
- Reset values: state IDLE, `rdata`=0, `stall`=0 (state terms only), `err`=0, `dev_req`=0, `dev_we`=0, `dev_id`=0, `dev_off`=0, `dev_wdata`=0, counter=0, `err_pending`=0.
- Reset asserted mid-access returns to IDLE immediately and `dev_req` drops. The CPU restarts, so no completion is owed.
- Minimum latency (ack in REQ): cycle 0 IDLE (`stall`), cycle 1 REQ, cycle 2 DONE. That is 3 cycles, 2 of them stalled.
- Ack after k cycles in WAIT: 3+k cycles total.
- Timeout: DONE is entered TIMEOUT+1 cycles after REQ.
- Decode error: cycle 0 IDLE, cycle 1 DONE with `err`=1.
- Back-to-back accesses: the cycle after DONE is IDLE and may start a new access. Minimum request spacing is 3 cycles.

## Test plan
- Write to LED: `addr`=FFFF_FC60, `io_write`=1, `wdata`=0F0F_0F0F, ack in REQ -> `dev_req` for one cycle with `dev_id`=0, `dev_we`=1, `dev_wdata`=0F0F; `stall` high for 2 cycles; `err`=0.
- Read switch: `addr`=FFFF_FC70, `io_read`=1, ack after 3 WAIT cycles with `dev_rdata`=FFFF -> `stall` high for 5 cycles; `rdata`=0000_FFFF in DONE and held afterwards.
- Timeout: read 0xFFFF_FC80, never ack, TIMEOUT=15 -> DONE 16 cycles after REQ; `err` pulses 1 cycle; `rdata`=0.
- Decode error: `addr`=FFFF_FC90 with `io_read`, and separately `io_read`=`io_write`=1 at FC60 -> no `dev_req`; `stall` for 1 cycle; `err` pulse.
- Reset in WAIT: assert `reset` 2 cycles after REQ -> all outputs reach their reset values asynchronously; a later `dev_ack` is ignored and `rdata` stays 0.
- Back-to-back: write FC60 then read FC70 with immediate acks -> two `dev_req` pulses 3 cycles apart; no spurious `err`.
